// File: rtl/adc_pkg.sv
// Shared FSM encoding and default parameters for the ADC offset-calibration front end.
package adc_pkg;
  localparam int DEF_W        = 19;
  localparam int DEF_ADC_BITS = 12;
  localparam int DEF_SHIFT    = 4;
  localparam int DEF_CAL_LOG2 = 4;
  localparam int STAGES       = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAL_ACC  = 2'd1,
    CAL_DONE = 2'd2
  } cal_state_e;
endpackage

// File: rtl/adc_sat_scale.sv
// Offset subtract with saturation to the signed ADC range, then arithmetic scale-down.
module adc_sat_scale #(
  parameter int ADC_BITS = 12,
  parameter int SHIFT    = 4,
  parameter int W        = 19
) (
  input  logic signed [ADC_BITS-1:0] conv,
  input  logic signed [ADC_BITS-1:0] offset,
  output logic        [W-1:0]        y,
  output logic                       sat
);
  logic [ADC_BITS:0]          diff;
  logic signed [ADC_BITS-1:0] satv;
  logic signed [ADC_BITS-1:0] sh;

  always_comb begin
    diff = {conv[ADC_BITS-1], conv} - {offset[ADC_BITS-1], offset};
    // top two bits disagree only when the difference left the ADC_BITS range
    sat  = diff[ADC_BITS] ^ diff[ADC_BITS-1];
    satv = sat ? {diff[ADC_BITS], {(ADC_BITS-1){~diff[ADC_BITS]}}} : diff[ADC_BITS-1:0];
    sh   = satv >>> SHIFT;
    y    = W'(sh);
  end
endmodule

// File: rtl/adc_offset_cal.sv
// ADC front end: offset-binary to signed, offset removal, scaling, plus averaging offset calibration.
module adc_offset_cal
  import adc_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int ADC_BITS = DEF_ADC_BITS,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [15:0]         Dato_IN,
  input  logic                Dato_valid,
  input  logic                Cal_start,
  output logic [W-1:0]        yOUT,
  output logic                yOUT_valid,
  output logic [3:0]          ProtocoloADC,
  output logic                Sat,
  output logic                Cal_busy,
  output logic                Cal_done,
  output logic [ADC_BITS-1:0] Offset_out
);
  localparam int ACC_W = ADC_BITS + CAL_LOG2;

  cal_state_e state, state_nxt;

  logic signed [ADC_BITS-1:0] conv, conv1, offset, y_off;
  logic [3:0]                 proto1;
  logic [STAGES:1]            vld_pipe;
  logic signed [ACC_W-1:0]    acc, sum;
  logic [CAL_LOG2-1:0]        cnt;
  logic                       accept, cal_smp, cal_last, sat_c;
  logic [W-1:0]               y_c;

  assign conv     = {~Dato_IN[ADC_BITS-1], Dato_IN[ADC_BITS-2:0]};
  assign accept   = Dato_valid && (state != CAL_ACC);
  assign cal_smp  = Dato_valid && (state == CAL_ACC);
  assign cal_last = cal_smp && (cnt == '1);
  assign sum      = acc + ACC_W'(conv);
  assign y_off    = conv1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Cal_start) state_nxt = CAL_ACC;
      CAL_ACC:  if (cal_last)  state_nxt = CAL_DONE;
      CAL_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign Cal_busy   = (state != IDLE);
  assign Cal_done   = (state == CAL_DONE);
  assign Offset_out = offset;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // calibration accumulator: cleared on entry, last sample folded in directly
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc    <= '0;
      cnt    <= '0;
      offset <= '0;
    end else if (state == IDLE && Cal_start) begin
      acc <= '0;
      cnt <= '0;
    end else if (cal_smp) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      if (cal_last) offset <= ADC_BITS'(sum >>> CAL_LOG2);
    end
  end

  adc_sat_scale #(.ADC_BITS(ADC_BITS), .SHIFT(SHIFT), .W(W)) u_sat_scale (
    .conv   (y_off),
    .offset (offset),
    .y      (y_c),
    .sat    (sat_c)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe     <= '0;
      conv1        <= '0;
      proto1       <= '0;
      yOUT         <= '0;
      Sat          <= 1'b0;
      ProtocoloADC <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        conv1  <= conv;
        proto1 <= Dato_IN[15:12];
      end
      if (vld_pipe[1]) begin
        yOUT         <= y_c;
        Sat          <= sat_c;
        ProtocoloADC <= proto1;
      end
    end
  end

  assign yOUT_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_adc_offset_cal.sv
// Directed bench for adc_offset_cal at default parameters.
module tb_adc_offset_cal;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Dato_IN = '0;
  logic        Dato_valid = 1'b0;
  logic        Cal_start = 1'b0;
  logic [18:0] yOUT;
  logic        yOUT_valid;
  logic [3:0]  ProtocoloADC;
  logic        Sat;
  logic        Cal_busy;
  logic        Cal_done;
  logic [11:0] Offset_out;

  int checks = 0;
  int errors = 0;

  localparam logic [18:0] Y_NEG128 = 19'h7FF80;

  adc_offset_cal dut (
    .Clk(Clk), .Reset_n(Reset_n), .Dato_IN(Dato_IN), .Dato_valid(Dato_valid),
    .Cal_start(Cal_start), .yOUT(yOUT), .yOUT_valid(yOUT_valid),
    .ProtocoloADC(ProtocoloADC), .Sat(Sat), .Cal_busy(Cal_busy),
    .Cal_done(Cal_done), .Offset_out(Offset_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_yvalid", {31'd0, yOUT_valid}, 32'd0);
    chk("rst_yout", {13'd0, yOUT}, 32'd0);
    chk("rst_busy", {31'd0, Cal_busy}, 32'd0);
    chk("rst_offset", {20'd0, Offset_out}, 32'd0);
    Reset_n = 1'b1;
    step();

    // midscale sample with protocol bits, 2-cycle latency
    Dato_IN = 16'h3800; Dato_valid = 1'b1;
    step();
    Dato_valid = 1'b0;
    chk("lat_early", {31'd0, yOUT_valid}, 32'd0);
    step();
    chk("mid_valid", {31'd0, yOUT_valid}, 32'd1);
    chk("mid_yout", {13'd0, yOUT}, 32'd0);
    chk("mid_proto", {28'd0, ProtocoloADC}, 32'h3);
    chk("mid_sat", {31'd0, Sat}, 32'd0);

    // full-scale back-to-back
    Dato_IN = 16'h0FFF; Dato_valid = 1'b1;
    step();
    Dato_IN = 16'h0000;
    step();
    Dato_valid = 1'b0;
    chk("fs_pos_valid", {31'd0, yOUT_valid}, 32'd1);
    chk("fs_pos_yout", {13'd0, yOUT}, 32'h7F);
    chk("fs_pos_proto", {28'd0, ProtocoloADC}, 32'h0);
    step();
    chk("fs_neg_valid", {31'd0, yOUT_valid}, 32'd1);
    chk("fs_neg_yout", {13'd0, yOUT}, {13'd0, Y_NEG128});
    step();
    chk("hold_valid", {31'd0, yOUT_valid}, 32'd0);
    chk("hold_yout", {13'd0, yOUT}, {13'd0, Y_NEG128});

    // calibration: 16 x conv=16 -> offset 16
    Cal_start = 1'b1;
    step();
    Cal_start = 1'b0;
    chk("cal_busy", {31'd0, Cal_busy}, 32'd1);
    Dato_IN = 16'h0810; Dato_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("cal_done_early", {31'd0, Cal_done}, 32'd0);
      step();
      chk("cal_no_yvalid", {31'd0, yOUT_valid}, 32'd0);
    end
    Dato_valid = 1'b0;
    chk("cal_done_pulse", {31'd0, Cal_done}, 32'd1);
    chk("cal_offset", {20'd0, Offset_out}, 32'h010);
    chk("cal_busy_done", {31'd0, Cal_busy}, 32'd1);
    step();
    chk("cal_done_end", {31'd0, Cal_done}, 32'd0);
    chk("cal_busy_end", {31'd0, Cal_busy}, 32'd0);

    Dato_IN = 16'h0810; Dato_valid = 1'b1;
    step();
    Dato_IN = 16'h0000;
    step();
    Dato_valid = 1'b0;
    chk("post_cal_yout", {13'd0, yOUT}, 32'd0);
    chk("post_cal_sat", {31'd0, Sat}, 32'd0);
    step();
    chk("clip_neg_yout", {13'd0, yOUT}, {13'd0, Y_NEG128});
    chk("clip_neg_sat", {31'd0, Sat}, 32'd1);

    // abort calibration with reset after 8 samples
    Cal_start = 1'b1;
    step();
    Cal_start = 1'b0;
    Dato_IN = 16'h0810; Dato_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    Dato_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Cal_busy}, 32'd0);
    chk("abort_offset", {20'd0, Offset_out}, 32'd0);
    chk("abort_done", {31'd0, Cal_done}, 32'd0);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", {31'd0, Cal_done}, 32'd0);
    end

    // restart with a simultaneous sample (processed, not accumulated); conv=-16
    Cal_start = 1'b1; Dato_IN = 16'h0900; Dato_valid = 1'b1;
    step();
    Cal_start = 1'b0; Dato_IN = 16'h07F0;
    step();
    chk("cs_sample_valid", {31'd0, yOUT_valid}, 32'd1);
    chk("cs_sample_yout", {13'd0, yOUT}, 32'h10);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("cal2_no_yvalid", {31'd0, yOUT_valid}, 32'd0);
    end
    Dato_valid = 1'b0;
    chk("cal2_done", {31'd0, Cal_done}, 32'd1);
    chk("cal2_offset", {20'd0, Offset_out}, 32'hFF0);
    step();
    Dato_IN = 16'h07F0; Dato_valid = 1'b1;
    step();
    Dato_IN = 16'h0FFF;
    step();
    Dato_valid = 1'b0;
    chk("cal2_zero", {13'd0, yOUT}, 32'd0);
    step();
    chk("clip_pos_yout", {13'd0, yOUT}, 32'h7F);
    chk("clip_pos_sat", {31'd0, Sat}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
